// File: rtl/tag_check_pkg.sv
// Shared definitions for the instruction-cache tag-check stage.
// Holds the tag-array row geometry, the way-entry layout (valid bit on top,
// tag below it), the FSM state encoding, and small row-manipulation helpers.
package tag_check_pkg;

  localparam int unsigned TAG_WIDTH   = 7;
  localparam int unsigned NUM_WAYS    = 4;
  localparam int unsigned BLOCK_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH  = 4;
  localparam int unsigned VALID_BIT   = BLOCK_WIDTH - 1;
  localparam int unsigned WAY_WIDTH   = 2;
  localparam int unsigned ROW_WIDTH   = NUM_WAYS * BLOCK_WIDTH;
  localparam int unsigned STAT_WIDTH  = 16;

  typedef logic [TAG_WIDTH-1:0]  tag_t;
  typedef logic [ADDR_WIDTH-1:0] set_t;
  typedef logic [WAY_WIDTH-1:0]  way_t;
  typedef logic [ROW_WIDTH-1:0]  row_t;
  typedef logic [NUM_WAYS-1:0]   mask_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReq    = 2'd1,
    StWrite  = 2'd2,
    StReplay = 2'd3
  } state_e;

  // Row with one way entry overwritten by a freshly valid {1, tag} entry.
  function automatic row_t row_replace(row_t row, way_t way, tag_t tag);
    row_t r;
    r = row;
    r[way*BLOCK_WIDTH +: BLOCK_WIDTH] = {1'b1, tag};
    return r;
  endfunction

  function automatic mask_t way_onehot(way_t way);
    return mask_t'(1) << way;
  endfunction

endpackage

// File: rtl/tag_check_way_compare.sv
// tag_way_compare: purely combinational comparison of a request tag against
// every way entry of a tag-array row.
// Ports:
//   row_i       way entries, way k at [k*8 +: 8], bit 7 = valid
//   tag_i       request tag
//   hit_o       some valid way holds tag_i
//   way_o       lowest-index matching way (0 when no hit)
//   inv_way_o   lowest-index invalid way (0 when none)
//   any_inv_o   at least one way is invalid
module tag_way_compare
  import tag_check_pkg::*;
(
  input  logic [ROW_WIDTH-1:0] row_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 hit_o,
  output logic [WAY_WIDTH-1:0] way_o,
  output logic [WAY_WIDTH-1:0] inv_way_o,
  output logic                 any_inv_o
);

  always_comb begin
    hit_o     = 1'b0;
    way_o     = '0;
    inv_way_o = '0;
    any_inv_o = 1'b0;
    for (int unsigned k = 0; k < NUM_WAYS; k++) begin
      // First match in ascending order wins, so later ways never override.
      if (!hit_o && row_i[k*BLOCK_WIDTH + VALID_BIT] &&
          (row_i[k*BLOCK_WIDTH +: TAG_WIDTH] == tag_i)) begin
        hit_o = 1'b1;
        way_o = WAY_WIDTH'(k);
      end
      if (!any_inv_o && !row_i[k*BLOCK_WIDTH + VALID_BIT]) begin
        any_inv_o = 1'b1;
        inv_way_o = WAY_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/tag_check.sv
// tag_check: stage directly after the instruction-cache tag array.
// Compares the request tag with the four way entries of the registered row.
// Hits are reported one cycle later. A miss raises o_halt, issues a refill
// request, writes the updated row back to the tag array for one cycle and
// then replays the request as a hit (o_refilled=1).
// Ports:
//   clk, arst                 clock, asynchronous active-high reset
//   i_valid/i_tag/i_set/i_row lookup from the tag array
//   i_halt / o_halt           downstream stall in / stall to the tag array
//   o_valid/o_hit/o_refilled/o_way/o_set/o_tag   registered result
//   o_refill_req/_set/_tag/_way, i_refill_ack    refill handshake
//   o_w_valid/o_w_clk_en/o_w_addr/o_w_data/o_w_wmask  tag-array write port
// Optional: TAG_CHECK_STATS_EN adds o_hit_count / o_miss_count, saturating
// counters of accepted lookups (replays excluded).
module tag_check
  import tag_check_pkg::*;
(
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_valid,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  input  logic [ADDR_WIDTH-1:0] i_set,
  input  logic [ROW_WIDTH-1:0]  i_row,
  input  logic                  i_halt,
  output logic                  o_halt,
  output logic                  o_valid,
  output logic                  o_hit,
  output logic                  o_refilled,
  output logic [WAY_WIDTH-1:0]  o_way,
  output logic [ADDR_WIDTH-1:0] o_set,
  output logic [TAG_WIDTH-1:0]  o_tag,
  output logic                  o_refill_req,
  output logic [ADDR_WIDTH-1:0] o_refill_set,
  output logic [TAG_WIDTH-1:0]  o_refill_tag,
  output logic [WAY_WIDTH-1:0]  o_refill_way,
  input  logic                  i_refill_ack,
  output logic                  o_w_valid,
  output logic                  o_w_clk_en,
  output logic [ADDR_WIDTH-1:0] o_w_addr,
  output logic [ROW_WIDTH-1:0]  o_w_data,
`ifdef TAG_CHECK_STATS_EN
  output logic [STAT_WIDTH-1:0] o_hit_count,
  output logic [STAT_WIDTH-1:0] o_miss_count,
`endif
  output logic [NUM_WAYS-1:0]   o_w_wmask
);

  state_e state_q, state_d;
  way_t   ctr_q, ctr_d;

  // Miss context, also presented on the refill request outputs.
  set_t   cap_set_q, cap_set_d;
  tag_t   cap_tag_q, cap_tag_d;
  row_t   cap_row_q, cap_row_d;
  way_t   victim_q, victim_d;
  logic   refill_req_q, refill_req_d;

  // Result registers, frozen while downstream stalls.
  logic   valid_q, valid_d;
  logic   hit_q, hit_d;
  logic   refilled_q, refilled_d;
  way_t   way_q, way_d;
  set_t   set_q, set_d;
  tag_t   tag_q, tag_d;

  // Tag-array write port.
  logic   w_valid_q, w_valid_d;
  set_t   w_addr_q, w_addr_d;
  row_t   w_data_q, w_data_d;
  mask_t  w_wmask_q, w_wmask_d;

  logic   cmp_hit;
  way_t   cmp_way;
  way_t   cmp_inv_way;
  logic   cmp_any_inv;
  logic   accept;

  tag_way_compare u_compare (
    .row_i     (i_row),
    .tag_i     (i_tag),
    .hit_o     (cmp_hit),
    .way_o     (cmp_way),
    .inv_way_o (cmp_inv_way),
    .any_inv_o (cmp_any_inv)
  );

  assign accept = (state_q == StIdle) && i_valid && !i_halt;

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    cap_set_d    = cap_set_q;
    cap_tag_d    = cap_tag_q;
    cap_row_d    = cap_row_q;
    victim_d     = victim_q;
    refill_req_d = refill_req_q;
    valid_d      = valid_q;
    hit_d        = hit_q;
    refilled_d   = refilled_q;
    way_d        = way_q;
    set_d        = set_q;
    tag_d        = tag_q;
    w_valid_d    = 1'b0;
    w_addr_d     = '0;
    w_data_d     = '0;
    w_wmask_d    = '0;

    unique case (state_q)
      StIdle: begin
        if (!i_halt) begin
          if (i_valid) begin
            valid_d    = 1'b1;
            refilled_d = 1'b0;
            set_d      = i_set;
            tag_d      = i_tag;
            if (cmp_hit) begin
              hit_d = 1'b1;
              way_d = cmp_way;
            end else begin
              // Miss indication pulse; way is not meaningful here.
              hit_d        = 1'b0;
              way_d        = '0;
              cap_set_d    = i_set;
              cap_tag_d    = i_tag;
              cap_row_d    = i_row;
              victim_d     = cmp_any_inv ? cmp_inv_way : ctr_q;
              refill_req_d = 1'b1;
              state_d      = StReq;
            end
          end else begin
            valid_d    = 1'b0;
            hit_d      = 1'b0;
            refilled_d = 1'b0;
          end
        end
      end

      StReq: begin
        if (!i_halt) begin
          valid_d    = 1'b0;
          hit_d      = 1'b0;
          refilled_d = 1'b0;
        end
        if (i_refill_ack) begin
          refill_req_d = 1'b0;
          ctr_d        = ctr_q + 1'b1;
          w_valid_d    = 1'b1;
          w_addr_d     = cap_set_q;
          w_data_d     = row_replace(cap_row_q, victim_q, cap_tag_q);
          w_wmask_d    = way_onehot(victim_q);
          state_d      = StWrite;
        end
      end

      StWrite: begin
        if (!i_halt) begin
          valid_d    = 1'b0;
          hit_d      = 1'b0;
          refilled_d = 1'b0;
        end
        state_d = StReplay;
      end

      StReplay: begin
        if (!i_halt) begin
          valid_d    = 1'b1;
          hit_d      = 1'b1;
          refilled_d = 1'b1;
          way_d      = victim_q;
          set_d      = cap_set_q;
          tag_d      = cap_tag_q;
          state_d    = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= StIdle;
      ctr_q        <= '0;
      cap_set_q    <= '0;
      cap_tag_q    <= '0;
      cap_row_q    <= '0;
      victim_q     <= '0;
      refill_req_q <= 1'b0;
      valid_q      <= 1'b0;
      hit_q        <= 1'b0;
      refilled_q   <= 1'b0;
      way_q        <= '0;
      set_q        <= '0;
      tag_q        <= '0;
      w_valid_q    <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
      w_wmask_q    <= '0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      cap_set_q    <= cap_set_d;
      cap_tag_q    <= cap_tag_d;
      cap_row_q    <= cap_row_d;
      victim_q     <= victim_d;
      refill_req_q <= refill_req_d;
      valid_q      <= valid_d;
      hit_q        <= hit_d;
      refilled_q   <= refilled_d;
      way_q        <= way_d;
      set_q        <= set_d;
      tag_q        <= tag_d;
      w_valid_q    <= w_valid_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
      w_wmask_q    <= w_wmask_d;
    end
  end

`ifdef TAG_CHECK_STATS_EN
  logic [STAT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [STAT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (accept && cmp_hit && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + 1'b1;
    end
    if (accept && !cmp_hit && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign o_hit_count  = hit_cnt_q;
  assign o_miss_count = miss_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

  assign o_halt       = (state_q != StIdle) | i_halt;
  assign o_valid      = valid_q;
  assign o_hit        = hit_q;
  assign o_refilled   = refilled_q;
  assign o_way        = way_q;
  assign o_set        = set_q;
  assign o_tag        = tag_q;
  assign o_refill_req = refill_req_q;
  assign o_refill_set = cap_set_q;
  assign o_refill_tag = cap_tag_q;
  assign o_refill_way = victim_q;
  assign o_w_valid    = w_valid_q;
  assign o_w_clk_en   = w_valid_q;
  assign o_w_addr     = w_addr_q;
  assign o_w_data     = w_data_q;
  assign o_w_wmask    = w_wmask_q;

endmodule

// File: doc/tag_check.md
Name: tag_check

Overview:
- Pipeline stage directly downstream of the instruction-cache tag array.
- Takes the registered tag-array row (4 way entries) plus the propagated request tag and set, and compares the tag against all ways.
- On a hit, emits hit/way downstream after one registered cycle.
- On a miss, stalls upstream, issues a refill request, writes the updated row back through the tag-array write port, then replays the request as a hit.

Parameters:
- TAG_WIDTH, 7, tag bits per way entry; way entry = {valid, tag}, so it must equal BLOCK_WIDTH-1.
- NUM_WAYS, 4, ways per row; fixed by the tag-array row format.
- BLOCK_WIDTH, 8, bits per way entry.
- ADDR_WIDTH, 4, set index width.

Ports:
- clk  in  1  clock.
- arst  in  1  asynchronous active-high reset.
- i_valid  in  1  row/tag/set valid from tag array.
- i_tag  in  TAG_WIDTH  request tag.
- i_set  in  ADDR_WIDTH  set index aligned with i_row.
- i_row  in  NUM_WAYS*BLOCK_WIDTH  way entries; way k = bits [k*8+7:k*8], bit 7 = valid.
- i_halt  in  1  downstream stall.
- o_halt  out  1  stall to tag array (drives its i_halt).
- o_valid  out  1  result valid.
- o_hit  out  1  hit.
- o_refilled  out  1  result produced by the refill replay.
- o_way  out  2  hit way.
- o_set  out  ADDR_WIDTH  set of the result.
- o_tag  out  TAG_WIDTH  tag of the result.
- o_refill_req  out  1  refill request.
- o_refill_set  out  ADDR_WIDTH  set being refilled.
- o_refill_tag  out  TAG_WIDTH  tag being refilled.
- o_refill_way  out  2  victim way.
- i_refill_ack  in  1  refill done.
- o_w_valid  out  1  tag-array write enable.
- o_w_clk_en  out  1  tag-array write clock enable.
- o_w_addr  out  ADDR_WIDTH  write set.
- o_w_data  out  32  write row.
- o_w_wmask  out  NUM_WAYS  one-hot victim mask.

Behaviour:
- Reset (arst high, async): state IDLE, every output 0, replacement counter 0.
- FSM states: IDLE, REQ, WRITE, REPLAY.
- o_halt = (state != IDLE) | i_halt, combinational.
- IDLE, i_valid=1, i_halt=0, hit:
  - A hit is any way with valid=1 and tag equal to i_tag; the lowest-index matching way wins.
  - Next cycle: o_valid=1, o_hit=1, o_way, o_set, o_tag registered.
- IDLE, i_valid=1, i_halt=0, miss:
  - Capture set, tag and row; select victim = lowest invalid way, else replacement counter.
  - Next state REQ. o_valid=1 with o_hit=0 for that one cycle (miss indication).
- IDLE with i_valid=0: o_valid=0 next cycle.
- While i_halt=1: output registers hold and inputs are ignored. o_halt to the tag array therefore freezes its output registers.
- REQ:
  - o_refill_req=1 (registered) with set/tag/way stable until i_refill_ack=1.
  - On ack: next state WRITE, replacement counter +1 (mod 4).
  - i_refill_ack in any other state is ignored.
- WRITE, exactly one cycle:
  - o_w_valid=1, o_w_clk_en=1, o_w_addr=captured set, o_w_wmask=one-hot victim.
  - o_w_data = captured row with the victim entry replaced by {1'b1, tag}.
  - Next state REPLAY.
- REPLAY:
  - When i_halt=0: o_valid=1, o_hit=1, o_refilled=1, o_way=victim for one cycle, then IDLE.
  - When i_halt=1: stays in REPLAY.
- i_valid is ignored in every state other than IDLE; the next request is held upstream by o_halt.
- Hit latency: 1 cycle. Miss latency to result: 3 cycles + ack wait.
- Reset mid-refill: request drops immediately and no write is issued.

Optional Feature:
- Macro: TAG_CHECK_STATS_EN.
- Defined:
  - Adds outputs o_hit_count[15:0] and o_miss_count[15:0], saturating at 16'hFFFF.
  - Counters increment once per accepted IDLE lookup; replays are not counted. Reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds: NUM_WAYS, BLOCK_WIDTH, ADDR_WIDTH, the way-entry layout (valid bit index 7), and state encodings.
- Natural sub-module: tag_way_compare, purely combinational. It takes row and tag and produces hit, way, first-invalid-way and any-invalid.

Test Plan:
- Reset, then i_valid=1, i_tag=7'h15, i_set=3, i_row way2=8'h95 → next cycle o_valid=1, o_hit=1, o_way=2, o_set=3, o_halt=0.
- i_row all 0, i_tag=7'h2A, i_set=5 → o_hit=0 pulse and o_refill_req=1 with set=5, way=0, o_halt=1. Ack after 4 cycles → one cycle of o_w_valid=1, wmask=4'b0001, w_data=32'h000000AA. Then o_hit=1, o_refilled=1, o_way=0; o_halt drops.
- Row all ways valid with non-matching tags, three misses → victims 0, 1, 2 (round-robin counter).
- Two ways match tag 7'h11 (ways 1 and 3) → o_way=1.
- i_halt=1 during REPLAY for 3 cycles → result held, single o_valid pulse after release.
- arst pulsed during REQ → o_refill_req=0 immediately, no w_valid, state IDLE. With TAG_CHECK_STATS_EN: 3 hits + 2 misses → counts 3 and 2.
